// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared fp32 helpers for the CNN post-processing stages.
//            FP_ZERO      : canonical +0.0 bit pattern
//            relu_fp32    : sign test, negative (incl. -0) -> +0
//            max_pos_fp32 : max of two non-negative fp32 values
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  function automatic logic [31:0] relu_fp32(input logic [31:0] x);
    return x[31] ? FP_ZERO : x;
  endfunction

  // For non-negative IEEE-754 values the bit patterns order exactly like the
  // values, so an unsigned integer compare is enough. +NaN sits above +Inf
  // and therefore wins, which is the propagation behaviour we want.
  function automatic logic [31:0] max_pos_fp32(input logic [31:0] a,
                                               input logic [31:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relu_maxpool2x2_stream_if.sv
// ============================================================================
// Module   : relu_maxpool2x2_stream_if
// Purpose  : Stream bundle for the ReLU + 2x2 max-pool stage.
//            valid_in / data_in              : raster-ordered input samples
//            valid_out / data_out / frame_done : pooled output samples
//            master : producer/consumer side, slave : the pooling stage
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface relu_maxpool2x2_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport master (
    output valid_in, data_in,
    input  valid_out, data_out, frame_done
  );

  modport slave (
    input  valid_in, data_in,
    output valid_out, data_out, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/pool_row_buffer.sv
// ============================================================================
// Module   : pool_row_buffer
// Purpose  : Simple dual-port line store holding the horizontal pair maxima
//            of the even row. One write port, one registered read port;
//            no reset on the storage so it maps onto distributed/block RAM.
//            clk       : clock
//            i_wr_*    : write enable / address / data
//            i_rd_*    : read enable / address
//            o_rd_data : registered read data, held while i_rd_en is low
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pool_row_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 28,
  parameter int ADDR_W     = 5
) (
  input  wire logic                  clk,
  input  wire logic                  i_wr_en,
  input  wire logic [ADDR_W-1:0]     i_wr_addr,
  input  wire logic [DATA_WIDTH-1:0] i_wr_data,
  input  wire logic                  i_rd_en,
  input  wire logic [ADDR_W-1:0]     i_rd_addr,
  output logic      [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/relu_maxpool2x2_stream.sv
// ============================================================================
// Module   : relu_maxpool2x2_stream
// Purpose  : Streaming ReLU followed by 2x2 / stride-2 max pooling on a
//            raster-ordered fp32 feature map, no backpressure.
//            clk  : clock, rising edge
//            rst  : asynchronous reset, active low
//            bus  : slave side of relu_maxpool2x2_stream_if
//                   (valid_in, data_in, valid_out, data_out, frame_done)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module relu_maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input wire logic                 clk,
  input wire logic                 rst,
  relu_maxpool2x2_stream_if.slave  bus
);

  localparam int c_DEPTH  = WIDTH / 2;
  localparam int c_COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int c_ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int c_ADDR_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

  generate
    if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0 || WIDTH < 2 || HEIGHT < 2) begin : g_bad_dims
      $error("relu_maxpool2x2_stream: WIDTH and HEIGHT must be even and >= 2");
    end
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("relu_maxpool2x2_stream: DATA_WIDTH must be 32 (binary32)");
    end
  endgenerate

  logic [c_COL_W-1:0]  r_col;
  logic [c_ROW_W-1:0]  r_row;
  logic [31:0]         r_h_hold;
  logic                r_valid_out;
  logic [31:0]         r_data_out;
  logic                r_frame_done;

  logic                w_col_odd;
  logic                w_row_odd;
  logic                w_col_last;
  logic                w_row_last;
  logic [31:0]         w_relu;
  logic [31:0]         w_h_max;
  logic [31:0]         w_rd_data;
  logic [31:0]         w_pool;
  logic [c_ADDR_W-1:0] w_addr;
  logic                w_wr_en;
  logic                w_rd_en;

  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];
  assign w_col_last = (r_col == c_COL_W'(WIDTH - 1));
  assign w_row_last = (r_row == c_ROW_W'(HEIGHT - 1));
  assign w_relu     = relu_fp32(bus.data_in);
  assign w_h_max    = max_pos_fp32(r_h_hold, w_relu);
  assign w_pool     = max_pos_fp32(w_rd_data, w_h_max);
  assign w_addr     = c_ADDR_W'(r_col >> 1);

  // Even rows store the pair maximum; odd rows fetch it one accepted pixel
  // early (on the even column) so the registered read is ready for the
  // odd column, however many idle cycles sit between the two pixels.
  assign w_wr_en = bus.valid_in &  w_col_odd & ~w_row_odd;
  assign w_rd_en = bus.valid_in & ~w_col_odd &  w_row_odd;

  pool_row_buffer #(
    .DATA_WIDTH (32),
    .DEPTH      (c_DEPTH),
    .ADDR_W     (c_ADDR_W)
  ) u_row_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_addr),
    .i_wr_data (w_h_max),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_h_hold     <= FP_ZERO;
      r_valid_out  <= 1'b0;
      r_data_out   <= FP_ZERO;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.valid_in) begin
        if (!w_col_odd) begin
          r_h_hold <= w_relu;
        end else if (w_row_odd) begin
          r_data_out   <= w_pool;
          r_valid_out  <= 1'b1;
          r_frame_done <= w_col_last & w_row_last;
        end

        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + c_ROW_W'(1);
        end else begin
          r_col <= r_col + c_COL_W'(1);
        end
      end
    end
  end

  assign bus.valid_out  = r_valid_out;
  assign bus.data_out   = r_data_out;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool2x2_stream.sv
// ============================================================================
// Module   : tb_relu_maxpool2x2_stream
// Purpose  : Self-checking bench for relu_maxpool2x2_stream: a 4x4 instance
//            driven from a table of hand-computed frames plus a 56x56
//            instance checked against a small reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_relu_maxpool2x2_stream;

  typedef struct packed {
    logic [0:15][31:0] px;
    logic [0:3][31:0]  ex;
  } vec_t;

  logic clk;
  logic rst4;
  logic rst56;

  int n_cmp;
  int n_fail;
  int n56_v;
  int n56_fd;

  logic [31:0] last4;
  logic [31:0] last56;
  logic [31:0] f56 [0:3135];
  vec_t        tbl [0:4];

  relu_maxpool2x2_stream_if #(.DATA_WIDTH(32)) sb ();
  relu_maxpool2x2_stream_if #(.DATA_WIDTH(32)) bb ();

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (sb)
  );

  relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(56), .HEIGHT(56)) dut56 (
    .clk (clk),
    .rst (rst56),
    .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] m_max(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic step(input bit big, input logic v, input logic [31:0] d,
                      input logic ev, input logic [31:0] ed, input logic efd,
                      input string nm);
    logic av;
    logic afd;
    logic [31:0] ad;
    if (big) begin
      bb.valid_in = v;
      bb.data_in  = d;
    end else begin
      sb.valid_in = v;
      sb.data_in  = d;
    end
    @(posedge clk);
    @(negedge clk);
    if (big) begin
      av  = bb.valid_out;
      ad  = bb.data_out;
      afd = bb.frame_done;
      if (av === 1'b1)  n56_v++;
      if (afd === 1'b1) n56_fd++;
    end else begin
      av  = sb.valid_out;
      ad  = sb.data_out;
      afd = sb.frame_done;
    end
    chk({nm, " valid_out"},  {31'b0, av},  {31'b0, ev});
    chk({nm, " data_out"},   ad,           ed);
    chk({nm, " frame_done"}, {31'b0, afd}, {31'b0, efd});
  endtask

  task automatic run4(input logic [0:15][31:0] px, input logic [0:3][31:0] ex,
                      input int maxgap, input string nm);
    for (int i = 0; i < 16; i++) begin
      int r;
      int c;
      int gap;
      logic ev;
      r = i / 4;
      c = i % 4;
      gap = 0;
      if (maxgap > 0) gap = int'($urandom_range(maxgap, (c % 2 == 1) ? 1 : 0));
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, $urandom, 1'b0, last4, 1'b0, nm);
      ev = (r % 2 == 1) && (c % 2 == 1);
      if (ev) last4 = ex[(r / 2) * 2 + c / 2];
      step(1'b0, 1'b1, px[i], ev, last4, (i == 15), nm);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    n56_v  = 0;
    n56_fd = 0;
    last4  = 32'h0;
    last56 = 32'h0;

    // ramp 1.0 .. 16.0
    tbl[0].px = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                 32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    tbl[0].ex = {32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    // all -1.0 plus one -0.0
    tbl[1].px = {32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                 32'hBF800000, 32'h80000000, 32'hBF800000, 32'hBF800000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
    tbl[1].ex = {32'h0, 32'h0, 32'h0, 32'h0};
    // {-5,2.5,0.5,-0} | NaN window | {1,-2,3,0.25} | {-3,-3,-3,+Inf}
    tbl[2].px = {32'hC0A00000, 32'h40200000, 32'h3F800000, 32'h42C80000,
                 32'h3F000000, 32'h80000000, 32'h7FC00000, 32'h3F800000,
                 32'h3F800000, 32'hC0000000, 32'hC0400000, 32'hC0400000,
                 32'h40400000, 32'h3E800000, 32'hC0400000, 32'h7F800000};
    tbl[2].ex = {32'h40200000, 32'h7FC00000, 32'h40400000, 32'h7F800000};
    // descending ramp 16.0 .. 1.0: max in the even-row even-col corner
    tbl[3].px = {32'h41800000, 32'h41700000, 32'h41600000, 32'h41500000,
                 32'h41400000, 32'h41300000, 32'h41200000, 32'h41100000,
                 32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    tbl[3].ex = {32'h41800000, 32'h41600000, 32'h41000000, 32'h40C00000};
    // background 1.0, peaks at (0,1)=5, (1,2)=7, (2,1)=9, (3,2)=11
    tbl[4].px = {32'h3F800000, 32'h40A00000, 32'h3F800000, 32'h3F800000,
                 32'h3F800000, 32'h3F800000, 32'h40E00000, 32'h3F800000,
                 32'h3F800000, 32'h41100000, 32'h3F800000, 32'h3F800000,
                 32'h3F800000, 32'h3F800000, 32'h41300000, 32'h3F800000};
    tbl[4].ex = {32'h40A00000, 32'h40E00000, 32'h41100000, 32'h41300000};

    sb.valid_in = 1'b0;
    sb.data_in  = 32'h0;
    bb.valid_in = 1'b0;
    bb.data_in  = 32'h0;
    rst4  = 1'b0;
    rst56 = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset4 valid_out",  {31'b0, sb.valid_out},  32'h0);
    chk("reset4 data_out",   sb.data_out,            32'h0);
    chk("reset4 frame_done", {31'b0, sb.frame_done}, 32'h0);
    chk("reset56 valid_out", {31'b0, bb.valid_out},  32'h0);
    chk("reset56 data_out",  bb.data_out,            32'h0);
    rst4  = 1'b1;
    rst56 = 1'b1;
    step(1'b0, 1'b0, 32'h12345678, 1'b0, last4, 1'b0, "idle");

    // Table frames back to back: no bubble across frame boundaries.
    for (int t = 0; t < 5; t++) run4(tbl[t].px, tbl[t].ex, 0, $sformatf("vec%0d", t));

    // Same ramp with random idle gaps, always at least one inside each pair.
    run4(tbl[0].px, tbl[0].ex, 5, "gapped_ramp");

    // Mid-frame reset at pixel (1,0), then a fresh frame.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, tbl[1].px[i], 1'b0, last4, 1'b0, "rst_pre");
    sb.valid_in = 1'b1;
    sb.data_in  = tbl[0].px[4];
    rst4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_reset valid_out",  {31'b0, sb.valid_out},  32'h0);
    chk("in_reset data_out",   sb.data_out,            32'h0);
    chk("in_reset frame_done", {31'b0, sb.frame_done}, 32'h0);
    rst4  = 1'b1;
    last4 = 32'h0;
    step(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, last4, 1'b0, "post_reset_idle");
    run4(tbl[0].px, tbl[0].ex, 0, "post_reset_ramp");

    // Two back-to-back 56x56 random frames against the reference model.
    for (int f = 0; f < 2; f++) begin
      n56_v  = 0;
      n56_fd = 0;
      for (int i = 0; i < 3136; i++) f56[i] = $urandom;
      for (int i = 0; i < 3136; i++) begin
        int r;
        int c;
        logic ev;
        r  = i / 56;
        c  = i % 56;
        ev = (r % 2 == 1) && (c % 2 == 1);
        if (ev) begin
          last56 = m_max(m_max(m_relu(f56[i - 57]), m_relu(f56[i - 56])),
                         m_max(m_relu(f56[i - 1]),  m_relu(f56[i])));
        end
        step(1'b1, 1'b1, f56[i], ev, last56, (i == 3135), $sformatf("big_f%0d", f));
      end
      chk($sformatf("big_f%0d output count", f), n56_v, 784);
      chk($sformatf("big_f%0d frame_done count", f), n56_fd, 1);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, last56, 1'b0, "big_tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/relu_maxpool2x2_stream.md
# relu_maxpool2x2_stream

Streaming ReLU + 2×2/stride-2 max-pool stage placed directly downstream of a `featuremap_conv2d_*` filter block. Consumes that block's raster-ordered IEEE-754 single-precision output (`data_out`/`valid_out`) and emits the pooled, rectified feature map at half width and half height. It has no backpressure, matching the producer. Output feeds the next layer's per-channel FIFO.

## Interface
- `DATA_WIDTH`, 32: sample width (IEEE-754 binary32).
- `WIDTH`, 56: input feature-map columns; must be even.
- `HEIGHT`, 56: input feature-map rows; must be even.
- `clk`  input  1  clock; all logic on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `valid_in`  input  1  one input sample is presented this cycle (producer's `valid_out`).
- `data_in`  input  DATA_WIDTH  input sample, raster order, row-major.
- `valid_out`  output  1  single-cycle pulse; one pooled sample is on `data_out`.
- `data_out`  output  DATA_WIDTH  pooled, rectified sample.
- `frame_done`  output  1  single-cycle pulse, coincident with the last `valid_out` of a frame.

## Operation
- ReLU: if `data_in[31]`=1, replace the sample with +0 (32'h0). This also maps -0 to +0.
- After ReLU all operands are non-negative. The max is therefore an unsigned compare of the 32-bit patterns. +NaN compares as largest and propagates.
- Counters: `col` runs 0..WIDTH-1 and `row` runs 0..HEIGHT-1. Both advance only on `valid_in`. `col` wraps to 0 and increments `row`. `row` wraps to 0 after HEIGHT-1, which starts the next frame.
- Even `col`: latch the rectified sample into `h_hold`.
- Odd `col`: `h_max = max(h_hold, relu(data_in))`.
  - Even `row`: write `h_max` to row buffer entry `col>>1`. Depth is WIDTH/2.
  - Odd `row`: result = `max(rowbuf[col>>1], h_max)`. Register it to `data_out` and pulse `valid_out`.
- Output count per frame: (WIDTH/2)·(HEIGHT/2) samples, in raster order of the pooled map.
- `frame_done` pulses with the output for `row`=HEIGHT-1, `col`=WIDTH-1.
- Idle cycles (`valid_in`=0) anywhere, including between the two pixels of a pair, leave all state unchanged.
- Row buffer contents are not reset. Each entry is always written in the even row before it is read in the odd row.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `frame_done`=0, `col`=0, `row`=0, `h_hold`=0.
- Latency: the output is registered. `valid_out` is high in the cycle after the rising edge that accepts the odd-row, odd-column input.
- `data_out` holds its last value between pulses.
- Maximum throughput: one output every 2 accepted inputs during odd rows. Back-to-back `valid_in` is sustained indefinitely.
- Row buffer: one write per pair in even rows, one read per pair in odd rows. It never reads and writes the same entry in the same cycle.
  - A registered read is allowed if issued on the even-column cycle, so that `rowbuf` is ready at the odd-column cycle.
- Frame wrap: the cycle after the last input of a frame, counters are 0. The first sample of the next frame is accepted with no bubble.
- Reset asserted mid-frame: outputs and counters clear asynchronously. The partial frame is discarded. After deassertion, the next `valid_in` is treated as pixel (0,0).
- Reset deassertion is synchronised externally; the block does not re-synchronise it.

## Structure
- Shared package `cnn_pkg`:
  - `FP_ZERO` constant.
  - `relu_fp32` function (sign test).
  - `max_pos_fp32` function (unsigned compare, valid only for non-negative operands).
- Sub-module `pool_row_buffer`: simple dual-port, WIDTH/2 × DATA_WIDTH, one write port, one read port. It is inferable as distributed or block RAM.
- Elaboration-time check: WIDTH and HEIGHT must both be even; fail the build otherwise.

## Test plan
- 4×4 frame, WIDTH=HEIGHT=4, values 1.0..16.0 in raster order, continuous `valid_in` -> outputs 6.0, 8.0, 14.0, 16.0. `frame_done` with 16.0. Each `valid_out` exactly 1 cycle after the input at (1,1), (1,3), (3,1), (3,3).
- 4×4 frame of all negatives (-1.0, i.e. 32'hBF800000) plus one -0.0 -> four outputs of 32'h00000000.
- Mixed window {-5.0, 2.5, 0.5, -0.0} in a 2×2 block -> 2.5 (32'h40200000). A window containing +NaN (32'h7FC00000) -> 32'h7FC00000.
- Same 4×4 ramp with random `valid_in` gaps, 0-5 idle cycles including between pair pixels -> identical output sequence. No `valid_out` during even rows.
- Two back-to-back 56×56 frames, random data vs. a reference model -> 784 outputs per frame, each matching. `frame_done` twice. No bubble at the frame boundary.
- `rst` asserted for 1 cycle at input (1,0) of a 4×4 frame, then a fresh frame -> no output from the aborted frame. `valid_out`/`data_out` read 0 during reset. The fresh frame gives the golden result.
